// File: rtl/seq_cascade_compare.sv
// seq_cascade_compare
//
// Byte-serial unsigned magnitude comparator for NBYTES-byte operands.
// Byte pairs arrive least-significant first. The three result flags are fed
// back as the cascade inputs for the next, more significant byte. Because of
// this, the flags after the last byte give the full-width comparison.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a comparison (sampled only in IDLE)
//   busy       high while in LOAD or DONE
//   in_valid   A_BYTE/B_BYTE pair is valid
//   in_ready   block accepts a byte pair (high only in LOAD)
//   A_BYTE     operand A byte, LSB byte first
//   B_BYTE     operand B byte, LSB byte first
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer takes the result
//   ALBO       A < B
//   AEBO       A == B
//   AGBO       A > B
module seq_cascade_compare #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] A_BYTE,
  input  logic [7:0] B_BYTE,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ALBO,
  output logic       AEBO,
  output logic       AGBO
);

  // The counter only has to reach NBYTES. It is cleared on every start, so it never wraps.
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  // Flags are packed as {ALBO, AEBO, AGBO}. All-zero means no result since reset.
  logic [2:0]     flags;
  logic [2:0]     flags_next;
  logic           accept;

  assign accept = (state == LOAD) && in_valid;

  // Next-state logic, and the cascade update of the flags.
  // If the bytes are equal, the flags keep their previous value. This lets a
  // lower-order decision pass through equal upper bytes. A different upper
  // byte overrides that decision.
  always_comb begin
    state_next = state;
    count_next = count;
    flags_next = flags;
    case (state)
      IDLE: begin
        if (start) begin
          flags_next = 3'b010;
          count_next = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (A_BYTE > B_BYTE) begin
            flags_next = 3'b001;
          end else if (A_BYTE < B_BYTE) begin
            flags_next = 3'b100;
          end
          count_next = count + CW'(1);
          if (count == LAST) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and flag registers. Reset clears everything without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      flags <= 3'b000;
    end else begin
      state <= state_next;
      count <= count_next;
      flags <= flags_next;
    end
  end

  // Handshake outputs are decoded from state only, so no input reaches an output combinationally.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);
  assign ALBO      = flags[2];
  assign AEBO      = flags[1];
  assign AGBO      = flags[0];

endmodule

// File: tb/tb_seq_cascade_compare.sv
// tb_seq_cascade_compare
//
// Directed bench for seq_cascade_compare with NBYTES=4.
// The stimulus side pushes a hand-computed final result into a queue when it
// issues a comparison. A monitor process pops that queue and compares it on
// every output handshake. Inline checks cover reset values, per-byte flags,
// gaps, backpressure and mid-operation reset.
module tb_seq_cascade_compare;

  localparam int NB = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A_BYTE;
  logic [7:0] B_BYTE;
  logic       out_valid;
  logic       out_ready;
  logic       ALBO;
  logic       AEBO;
  logic       AGBO;
  logic [2:0] flags;

  int         vectors;
  int         miscompares;
  logic [2:0] exp_q[$];

  assign flags = {ALBO, AEBO, AGBO};

  seq_cascade_compare #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_BYTE    (A_BYTE),
    .B_BYTE    (B_BYTE),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALBO      (ALBO),
    .AEBO      (AEBO),
    .AGBO      (AGBO)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one value and reports it in a single line
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side cascade model for the per-byte flags, packed {ALBO,AEBO,AGBO}
  function automatic logic [2:0] modelStep(input logic [2:0] cur, input logic [7:0] a, input logic [7:0] b);
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    return cur;
  endfunction

  // Called at posedge+1 in IDLE. Pulses start, then sends nsend byte pairs.
  // Between pairs, in_valid is held low for gap cycles. If pushExp is set, the
  // expected final result goes into the scoreboard.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int gap,
                               input int nsend, input logic [2:0] exp, input bit pushExp);
    logic [2:0] model;
    if (pushExp) exp_q.push_back(exp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_in_ready", 32'(in_ready), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_flags", 32'(flags), 32'b010);
    model = 3'b010;
    for (int i = 0; i < nsend; i++) begin
      A_BYTE   = a[8*i +: 8];
      B_BYTE   = b[8*i +: 8];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model = modelStep(model, a[8*i +: 8], b[8*i +: 8]);
      checkOutput($sformatf("byte%0d_flags", i), 32'(flags), 32'(model));
      if (i == NB - 1) begin
        checkOutput("last_out_valid", 32'(out_valid), 32'd1);
      end else if (i < nsend - 1) begin
        for (int g = 0; g < gap; g++) begin
          A_BYTE = 8'hFF;
          B_BYTE = 8'h00;
          @(posedge clk); #1;
          checkOutput("gap_flags", 32'(flags), 32'(model));
          checkOutput("gap_out_valid", 32'(out_valid), 32'd0);
          checkOutput("gap_in_ready", 32'(in_ready), 32'd1);
        end
      end
    end
  endtask

  // Waits (bounded) for out_valid, then completes the handshake. Returns at posedge+1, back in IDLE.
  task automatic finishResult();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL result_timeout: out_valid 0, expected 1 within 20 cycles");
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_hs_busy", 32'(busy), 32'd0);
    checkOutput("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Checks that every visible output is at its reset value
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_flags"}, 32'(flags), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: one pop per output handshake, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_result: got flags %b, expected no result", flags);
        end else begin
          checkOutput("result_flags", 32'(flags), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A_BYTE    = 8'h00;
    B_BYTE    = 8'h00;

    // Reset held for three cycles, with outputs checked during and after it
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkResetState("reset");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetState("post_reset");
    @(posedge clk); #1;

    // Equal operands, sent back to back
    applyStimulus(32'h12345678, 32'h12345678, 0, NB, 3'b010, 1'b1);
    finishResult();

    // A more significant byte overrides the low-byte decision
    applyStimulus(32'h01000000, 32'h00FFFFFF, 0, NB, 3'b001, 1'b1);
    finishResult();

    // Two-cycle gaps between every pair
    applyStimulus(32'h00000001, 32'h00000002, 2, NB, 3'b100, 1'b1);
    finishResult();

    // Backpressure in DONE while start and in_valid are pulsed
    out_ready = 1'b0;
    applyStimulus(32'h00000010, 32'h00000020, 0, NB, 3'b100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      start    = k[0];
      in_valid = ~k[0];
      A_BYTE   = 8'hFF;
      B_BYTE   = 8'h00;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_flags", 32'(flags), 32'b100);
    end
    in_valid  = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("hs_start_ignored_busy", 32'(busy), 32'd0);
    checkOutput("idle_flags_held", 32'(flags), 32'b100);
    // Start on the very next edge must be accepted
    applyStimulus(32'h00000000, 32'h00000000, 0, NB, 3'b010, 1'b1);
    finishResult();

    // Reset asserted between edges after two of four pairs
    applyStimulus(32'h00000203, 32'h00000302, 0, 2, 3'b000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("async_reset");
    @(posedge clk);
    @(negedge clk);
    checkResetState("async_reset_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_reset_busy", 32'(busy), 32'd0);
    applyStimulus(32'h000000FF, 32'h00000000, 0, NB, 3'b001, 1'b1);
    finishResult();

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_cascade_compare.md
# seq_cascade_compare

Byte-serial magnitude comparator for unsigned operands wider than 8 bits, NBYTES bytes each. It drives its own cascade inputs (less-than, equal, greater-than) from a feedback register, the way a chain of 8-bit cascade comparators would be wired. Operand byte pairs arrive least-significant byte first over a valid/ready stream, and the final three-way result leaves over a valid/ready handshake. It sits between the datapath byte buffers and any consumer of ALBO/AEBO/AGBO-style results.

## Interface
- NBYTES, default 4: bytes per operand; legal range 1..255.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a comparison; sampled only in IDLE
- busy  output  1  high in LOAD and DONE
- in_valid  input  1  byte pair A_BYTE/B_BYTE is valid
- in_ready  output  1  block accepts a byte pair; high only in LOAD
- A_BYTE  input  8  operand A byte, LSB byte first
- B_BYTE  input  8  operand B byte, LSB byte first
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer takes the result
- ALBO  output  1  A < B
- AEBO  output  1  A == B
- AGBO  output  1  A > B
- Clock and reset: one clock (clk), reset asynchronous active-low (rst_n).

## Operation
- State machine has three states: IDLE, LOAD and DONE.
- **IDLE:**
  - start=1 loads the flags to {ALBO,AEBO,AGBO}={0,1,0}, clears the byte counter to 0 and moves to LOAD.
  - start=0 keeps the block in IDLE and the flags keep their last values.
- **LOAD:**
  - in_ready=1.
  - Each cycle with in_valid&&in_ready is one accepted byte pair.
  - If A_BYTE > B_BYTE, flags become {0,0,1}.
  - If A_BYTE < B_BYTE, flags become {1,0,0}.
  - If the bytes are equal, the flags hold; this is the cascade input feedback.
  - The counter increments on each accepted pair.
  - Acceptance with counter == NBYTES-1 moves to DONE.
  - Each later, more significant byte overrides earlier results unless it is equal, so the final flags give the full-width unsigned comparison.
- **DONE:**
  - out_valid=1 and the flags are held stable.
  - out_valid&&out_ready moves to IDLE.
- Invariant: exactly one flag is high from the first start onward.
- The counter is ceil(log2(NBYTES+1)) bits wide. It never wraps, because it resets on every start.
- start is ignored in LOAD and DONE; a comparison cannot be re-armed mid-operation.
- in_valid is ignored outside LOAD; no byte is consumed.
- After the output handshake the flags keep the last result in IDLE until the next start.
- Reset (rst_n=0, at any time including mid-LOAD or in DONE):
  - Goes to IDLE immediately without waiting for clk.
  - Counter = 0.
  - ALBO=0, AEBO=0, AGBO=0 (the all-zero state marks "no result since reset").
  - out_valid=0, in_ready=0, busy=0.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- start sampled at edge t gives busy=1 and in_ready=1 from t+.
- Throughput is one byte pair per cycle. Gaps (in_valid=0) stall without changing state.
- If the last pair is accepted at edge k, out_valid=1 and final flags appear at k+, so latency is 0 cycles after the last byte.
- Total minimum time is NBYTES+1 cycles from start to out_valid.
- out_valid&&out_ready at edge m gives IDLE at m+.
- A start asserted in the same cycle as the output handshake is ignored. The earliest accepted start is at edge m+1.
- With NBYTES=1, a single accepted pair goes straight to DONE.
- Reset release: the first start is sampled at the first rising edge with rst_n=1.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles, then release. Expect ALBO/AEBO/AGBO=0/0/0, out_valid=0, in_ready=0 and busy=0 during and after reset until start.
- **Equal operands (NBYTES=4):** A=B=0x12345678, pairs sent back-to-back as 78/78, 56/56, 34/34, 12/12. Expect out_valid=1 in the cycle after the 4th acceptance with AEBO=1; ALBO and AGBO stay 0.
- **MSB override:** A=0x01000000, B=0x00FFFFFF. Expect the flags to be {1,0,0} after byte 0, and the final result AGBO=1, ALBO=0, AEBO=0.
- **Stalled input:** A=0x00000001, B=0x00000002, with in_valid low for 2 cycles between every pair. Expect the result ALBO=1, and the counter and flags unchanged during the gaps.
- **Output backpressure:** hold out_ready=0 for 5 cycles in DONE while pulsing start and in_valid. Expect the result stable, in_ready=0 and start ignored. After the handshake the block is in IDLE, and a start one cycle later is accepted.
- **Reset mid-operation:** assert rst_n low asynchronously (between edges) after 2 of 4 pairs. Expect the outputs to go to their reset values immediately. A fresh start with A=0xFF, 0, 0, 0 and B=0 yields AGBO=1 with no leftover state.
